// File: rtl/md_issue_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// md_issue_ctrl_pkg
//   Shared definitions for the mul/div issue controller: the ALU control
//   codes that delimit the mul/div op range and the controller state
//   encoding.
// ----------------------------------------------------------------------------
package md_issue_ctrl_pkg;

    // The eight mul/div ops occupy one contiguous block of ALU control
    // codes: MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU.
    // Only the two bounds are needed to classify an op.
    localparam logic [4:0] ALUCTRL_MUL  = 5'h10;
    localparam logic [4:0] ALUCTRL_REMU = 5'h17;

    typedef enum logic [1:0] {
        MD_STATE_IDLE  = 2'd0,  // no op outstanding
        MD_STATE_WAIT  = 2'd1,  // op issued, pipeline stalled until md_ready
        MD_STATE_DONE  = 2'd2,  // result presented to the EX instruction
        MD_STATE_DRAIN = 2'd3   // flushed op still in flight, result discarded
    } md_state_e;

endpackage

// File: rtl/md_issue_ctrl_watchdog.sv
// ----------------------------------------------------------------------------
// md_issue_ctrl_watchdog
//   Saturating wait counter with a sticky timeout flag.
//   Ports:
//     clk        clock, rising edge
//     rst        synchronous active-high reset
//     clear_i    restart the count (entry into a waiting state)
//     enable_i   count one more waited cycle
//     timeout_o  sticky, set once the count reaches TIMEOUT
// ----------------------------------------------------------------------------
module md_issue_ctrl_watchdog #(
    parameter int CNT_W   = 6,
    parameter int TIMEOUT = 40
) (
    input  logic clk,
    input  logic rst,
    input  logic clear_i,
    input  logic enable_i,
    output logic timeout_o
);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             flag_q, flag_d;

    always_comb begin
        cnt_d = cnt_q;
        // The entry cycle (issue or flush) is itself the first waited cycle,
        // so the count always equals cycles elapsed since entry.
        if (clear_i) begin
            cnt_d = CNT_W'(1);
        end else if (enable_i && (cnt_q != '1)) begin
            cnt_d = cnt_q + 1'b1;
        end
        flag_d = flag_q | (cnt_d == CNT_W'(TIMEOUT));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q  <= '0;
            flag_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            flag_q <= flag_d;
        end
    end

    assign timeout_o = flag_q;

endmodule

// File: rtl/md_issue_ctrl.sv
// ----------------------------------------------------------------------------
// md_issue_ctrl
//   EX-stage initiator for the multi-cycle mul/div unit. Issues a one-cycle
//   md_valid for a mul/div op, stalls the front of the pipeline until the
//   unit answers, registers and presents the result, and drains ops that
//   were flushed while in flight.
//   Ports:
//     clk, rst       clock; synchronous active-high reset
//     ex_valid       EX holds a valid instruction
//     ex_ctrl        ALU control of the EX instruction
//     ex_hold        downstream stall, EX must not advance
//     flush          kill the EX instruction
//     md_valid       one-cycle request to the mul/div unit
//     md_ready       unit result valid (one cycle)
//     md_result      unit result while md_ready
//     stall          hold IF/ID/EX
//     res_valid      res_data valid for the EX instruction
//     res_data       registered mul/div result
//     err_timeout    sticky: unit did not answer within TIMEOUT cycles
//     err_protocol   sticky: md_ready arrived with nothing outstanding
// ----------------------------------------------------------------------------
module md_issue_ctrl
    import md_issue_ctrl_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int CTRL_W  = 5,
    parameter int TIMEOUT = 40,
    parameter int CNT_W   = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ex_valid,
    input  logic [CTRL_W-1:0] ex_ctrl,
    input  logic              ex_hold,
    input  logic              flush,
    output logic              md_valid,
    input  logic              md_ready,
    input  logic [DATA_W-1:0] md_result,
    output logic              stall,
    output logic              res_valid,
    output logic [DATA_W-1:0] res_data,
    output logic              err_timeout,
    output logic              err_protocol
);

    md_state_e         state_q, state_d;
    logic [DATA_W-1:0] res_data_q, res_data_d;
    logic              err_protocol_q, err_protocol_d;
    logic              md_valid_c, stall_c, res_valid_c;
    logic              wd_clear, wd_enable, wd_timeout;
    logic              is_md;

    assign is_md = ex_valid
                && (ex_ctrl >= CTRL_W'(ALUCTRL_MUL))
                && (ex_ctrl <= CTRL_W'(ALUCTRL_REMU));

    // NOTE: every signal written here gets a default first, so no path
    // through the case leaves one unassigned and no latch is inferred.
    always_comb begin
        state_d     = state_q;
        res_data_d  = res_data_q;
        md_valid_c  = 1'b0;
        stall_c     = 1'b0;
        res_valid_c = 1'b0;
        wd_clear    = 1'b0;
        wd_enable   = 1'b0;

        unique case (state_q)
            MD_STATE_IDLE: begin
                // The only place md_valid can rise, so the unit never sees
                // a relaunch while it is returning to its own idle state.
                if (is_md && !flush) begin
                    md_valid_c = 1'b1;
                    stall_c    = 1'b1;
                    wd_clear   = 1'b1;
                    state_d    = MD_STATE_WAIT;
                end
            end
            MD_STATE_WAIT: begin
                stall_c = 1'b1;
                if (md_ready) begin
                    if (!flush) begin
                        res_data_d = md_result;
                        state_d    = MD_STATE_DONE;
                    end else begin
                        state_d = MD_STATE_IDLE;
                    end
                end else if (flush) begin
                    wd_clear = 1'b1;
                    state_d  = MD_STATE_DRAIN;
                end else begin
                    wd_enable = 1'b1;
                end
            end
            MD_STATE_DONE: begin
                // The op is still in EX here; it must not be issued again.
                res_valid_c = !flush;
                if (flush || !ex_hold) begin
                    state_d = MD_STATE_IDLE;
                end
            end
            MD_STATE_DRAIN: begin
                // A new op has to wait until the unit has returned the
                // killed op's result.
                stall_c = is_md;
                if (md_ready) begin
                    state_d = MD_STATE_IDLE;
                end else begin
                    wd_enable = 1'b1;
                end
            end
            default: state_d = MD_STATE_IDLE;
        endcase

        err_protocol_d = err_protocol_q
                       | (md_ready && ((state_q == MD_STATE_IDLE) || (state_q == MD_STATE_DONE)));
    end

    // NOTE: state registers use non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= MD_STATE_IDLE;
            res_data_q     <= '0;
            err_protocol_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            res_data_q     <= res_data_d;
            err_protocol_q <= err_protocol_d;
        end
    end

    md_issue_ctrl_watchdog #(
        .CNT_W   (CNT_W),
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clk       (clk),
        .rst       (rst),
        .clear_i   (wd_clear),
        .enable_i  (wd_enable),
        .timeout_o (wd_timeout)
    );

    // Registers only clear at the reset edge; gating keeps every output at
    // zero for the whole time rst is high.
    assign md_valid     = md_valid_c  & ~rst;
    assign stall        = stall_c     & ~rst;
    assign res_valid    = res_valid_c & ~rst;
    assign res_data     = rst ? '0 : res_data_q;
    assign err_timeout  = wd_timeout     & ~rst;
    assign err_protocol = err_protocol_q & ~rst;

endmodule
